// File: rtl/csr_func_pkg.sv
// csr_func_pkg: shared types, register offsets and default routing table for csr_func_responder
package csr_func_pkg;
  localparam int PF_W        = 3;
  localparam int VF_W        = 11;
  localparam int MAX_FUNCS   = 16;
  localparam int DFH_OFF     = 'h0;
  localparam int GUID_L_OFF  = 'h8;
  localparam int GUID_H_OFF  = 'h10;
  localparam int SCRATCH_OFF = 'h18;

  typedef struct packed {
    logic [PF_W-1:0] pf;
    logic [VF_W-1:0] vf;
    logic            va;
    logic [63:0]     dfh;
    logic [63:0]     guid_l;
    logic [63:0]     guid_h;
  } func_entry_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  // HE-LB, HE-MEM, HE-HSSI on PF0 VFs, VirtIO on PF3 with no VF
  localparam func_entry_t [3:0] DEFAULT_TABLE = '{
    0: '{pf: 3'd0, vf: 11'd0, va: 1'b1, dfh: 64'h1000_0000_0000_0001,
         guid_l: 64'h8A1A_5C3B_0F11_0001, guid_h: 64'h56E2_03A7_4C8D_0001},
    1: '{pf: 3'd0, vf: 11'd1, va: 1'b1, dfh: 64'h1000_0000_0000_0002,
         guid_l: 64'h8A1A_5C3B_0F11_0002, guid_h: 64'h56E2_03A7_4C8D_0002},
    2: '{pf: 3'd0, vf: 11'd2, va: 1'b1, dfh: 64'h1000_0000_0000_0003,
         guid_l: 64'h8A1A_5C3B_0F11_0003, guid_h: 64'h56E2_03A7_4C8D_0003},
    3: '{pf: 3'd3, vf: 11'd0, va: 1'b0, dfh: 64'h1000_0000_0000_0004,
         guid_l: 64'h8A1A_5C3B_0F11_0004, guid_h: 64'h56E2_03A7_4C8D_0004}
  };

  // vf only participates when the VF is active
  function automatic logic tuple_match(func_entry_t e, logic [PF_W-1:0] pf,
                                       logic [VF_W-1:0] vf, logic va);
    return e.pf == pf && e.va == va && (!va || e.vf == vf);
  endfunction
endpackage

// File: rtl/csr_func_responder_if.sv
// csr_func_responder_if: MMIO request / read-response channel of csr_func_responder
interface csr_func_responder_if import csr_func_pkg::*; #(
    parameter int ADDR_W = 20
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [PF_W-1:0]   req_pf;
    logic [VF_W-1:0]   req_vf;
    logic              req_va;
    logic [63:0]       req_wdata;
    logic [7:0]        req_be;
    logic [9:0]        req_tag;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_data;
    logic [9:0]        rsp_tag;
    logic              rsp_err;
    logic [15:0]       err_cnt;

    modport master (
        output req_valid, req_write, req_addr, req_pf, req_vf, req_va, req_wdata, req_be, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, err_cnt
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_pf, req_vf, req_va, req_wdata, req_be, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err, err_cnt
    );
endinterface

// File: rtl/csr_func_match.sv
// csr_func_match: parallel (pf, vf, va) compare against the function table, lowest index wins
module csr_func_match import csr_func_pkg::*; #(
    parameter int NUM_FUNCS = 4,
    parameter int IDX_W     = 2,
    parameter func_entry_t [NUM_FUNCS-1:0] FUNC_TABLE = DEFAULT_TABLE
) (
    input  logic [PF_W-1:0]  pf,
    input  logic [VF_W-1:0]  vf,
    input  logic             va,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_FUNCS - 1; i >= 0; i--)
            if (tuple_match(FUNC_TABLE[i], pf, vf, va)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
    end
endmodule

// File: rtl/csr_func_responder.sv
// csr_func_responder: table-driven MMIO CSR responder with per-function DFH/GUID and scratchpads
module csr_func_responder import csr_func_pkg::*; #(
    parameter int NUM_FUNCS   = 4,
    parameter int NUM_SCRATCH = 2,
    parameter int ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] FEAT_BASE = 'h20000,
    parameter func_entry_t [NUM_FUNCS-1:0] FUNC_TABLE = DEFAULT_TABLE
) (
    input logic clk,
    input logic rst,
    csr_func_responder_if.slave bus
);
    localparam int IDX_W = NUM_FUNCS > 1 ? $clog2(NUM_FUNCS) : 1;
    localparam int SW    = NUM_SCRATCH > 1 ? $clog2(NUM_SCRATCH) : 1;
    localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(SCRATCH_OFF + 8 * (NUM_SCRATCH - 1));

    state_t            state, nxt;
    logic              rdy_q;
    logic [15:0]       err_q;
    logic              wr_q, va_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PF_W-1:0]   pf_q;
    logic [VF_W-1:0]   vf_q;
    logic [63:0]       wdata_q;
    logic [7:0]        be_q;
    logic [9:0]        tag_q;
    logic [63:0]       rsp_data_q;
    logic [9:0]        rsp_tag_q;
    logic              rsp_err_q;
    logic [63:0]       scratch [NUM_FUNCS][NUM_SCRATCH];
    logic              hit, mapped, is_scr, acc;
    logic [IDX_W-1:0]  idx;
    logic [SW-1:0]     sidx;
    logic [ADDR_W-1:0] off;
    logic [63:0]       rd_data;
    func_entry_t       ent;

    csr_func_match #(.NUM_FUNCS(NUM_FUNCS), .IDX_W(IDX_W), .FUNC_TABLE(FUNC_TABLE)) u_match (
        .pf(pf_q), .vf(vf_q), .va(va_q), .hit(hit), .idx(idx)
    );

    // addresses below the window wrap to large offsets, but the explicit base check keeps intent clear
    assign off     = addr_q - FEAT_BASE;
    assign mapped  = hit && addr_q >= FEAT_BASE && addr_q[2:0] == 3'd0 && off <= LAST_OFF;
    assign is_scr  = off >= ADDR_W'(SCRATCH_OFF);
    assign sidx    = SW'((off - ADDR_W'(SCRATCH_OFF)) >> 3);
    assign ent     = FUNC_TABLE[idx];
    assign rd_data = !mapped ? 64'h0 :
                     off == ADDR_W'(DFH_OFF)    ? ent.dfh :
                     off == ADDR_W'(GUID_L_OFF) ? ent.guid_l :
                     off == ADDR_W'(GUID_H_OFF) ? ent.guid_h : scratch[idx][sidx];
    assign acc     = rdy_q && bus.req_valid;

    always_comb begin
        nxt = state;
        nxt = state == IDLE   ? (acc ? LOOKUP : IDLE) :
              state == LOOKUP ? (wr_q ? IDLE : RESP) :
              (bus.rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b0;
            err_q <= '0;
            {wr_q, va_q, addr_q, pf_q, vf_q, wdata_q, be_q, tag_q} <= '0;
            {rsp_data_q, rsp_tag_q, rsp_err_q} <= '0;
        end else begin
            state <= nxt;
            rdy_q <= nxt == IDLE;
            if (acc) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr;
                pf_q    <= bus.req_pf;
                vf_q    <= bus.req_vf;
                va_q    <= bus.req_va;
                wdata_q <= bus.req_wdata;
                be_q    <= bus.req_be;
                tag_q   <= bus.req_tag;
            end
            if (state == LOOKUP && !wr_q) {rsp_data_q, rsp_tag_q, rsp_err_q} <= {rd_data, tag_q, !mapped};
            if (state == LOOKUP && !mapped && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < NUM_FUNCS; f++)
                for (int s = 0; s < NUM_SCRATCH; s++) scratch[f][s] <= '0;
        end else if (state == LOOKUP && wr_q && mapped && is_scr) begin
            for (int b = 0; b < 8; b++)
                if (be_q[b]) scratch[idx][sidx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_csr_func_responder.sv
// tb_csr_func_responder: directed plus randomized checks against a table-lookup reference model
module tb_csr_func_responder;
    import csr_func_pkg::*;
    localparam int NF = 4;
    localparam int NS = 2;
    localparam logic [19:0] BASE = 20'h20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [63:0] scr_m [NF][NS];
    logic [15:0] err_m;
    logic [63:0] exp_d;
    logic        exp_e;
    logic [9:0]  cur_tag;
    logic [63:0] d;

    csr_func_responder_if #(.ADDR_W(20)) bus ();
    csr_func_responder #(.NUM_FUNCS(NF), .NUM_SCRATCH(NS), .ADDR_W(20), .FEAT_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // index of first table entry claiming this tuple, -1 if none
    function automatic int find(input logic [2:0] pf, input logic [10:0] vf, input logic va);
        for (int i = 0; i < NF; i++) begin
            if (DEFAULT_TABLE[i].pf != pf || DEFAULT_TABLE[i].va != va) continue;
            if (va && DEFAULT_TABLE[i].vf != vf) continue;
            return i;
        end
        return -1;
    endfunction

    function automatic int reg_no(input logic [19:0] addr);
        int o = int'(addr) - int'(BASE);
        if (o < 0 || o % 8 != 0 || o > 'h18 + 8 * (NS - 1)) return -1;
        return o / 8;
    endfunction

    task automatic model_clear();
        for (int f = 0; f < NF; f++)
            for (int s = 0; s < NS; s++) scr_m[f][s] = 64'h0;
        err_m = 16'h0;
    endtask

    task automatic drive(input logic wr, input logic [2:0] pf, input logic [10:0] vf, input logic va,
                         input logic [19:0] addr, input logic [63:0] wd, input logic [7:0] be);
        int n = 0;
        @(negedge clk);
        cur_tag = 10'($urandom);
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
        bus.req_pf = pf; bus.req_vf = vf; bus.req_va = va;
        bus.req_wdata = wd; bus.req_be = be; bus.req_tag = cur_tag;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        chk("accept_timeout", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("lookup_req_ready", 64'(bus.req_ready), 64'd0);
        chk("lookup_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    endtask

    task automatic rd_start(input logic [2:0] pf, input logic [10:0] vf, input logic va, input logic [19:0] addr);
        int f = find(pf, vf, va);
        int r = reg_no(addr);
        exp_e = f < 0 || r < 0;
        exp_d = exp_e ? 64'h0 : r == 0 ? DEFAULT_TABLE[f].dfh : r == 1 ? DEFAULT_TABLE[f].guid_l :
                r == 2 ? DEFAULT_TABLE[f].guid_h : scr_m[f][r-3];
        if (exp_e && err_m != 16'hFFFF) err_m++;
        drive(1'b0, pf, vf, va, addr, 64'h0, 8'h0);
        @(negedge clk);
        chk("rsp_valid_n2", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_data", bus.rsp_data, exp_d);
        chk("rsp_tag", 64'(bus.rsp_tag), 64'(cur_tag));
        chk("rsp_err", 64'(bus.rsp_err), 64'(exp_e));
        chk("err_cnt_rd", 64'(bus.err_cnt), 64'(err_m));
    endtask

    task automatic rd_finish(input int hold);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("hold_data", bus.rsp_data, exp_d);
            chk("hold_tag", 64'(bus.rsp_tag), 64'(cur_tag));
            chk("hold_err", 64'(bus.rsp_err), 64'(exp_e));
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
        chk("ready_after_rsp", 64'(bus.req_ready), 64'd1);
    endtask

    task automatic rd(input logic [2:0] pf, input logic [10:0] vf, input logic va, input logic [19:0] addr,
                      input int hold, output logic [63:0] data);
        rd_start(pf, vf, va, addr);
        data = bus.rsp_data;
        rd_finish(hold);
    endtask

    task automatic wr(input logic [2:0] pf, input logic [10:0] vf, input logic va, input logic [19:0] addr,
                      input logic [63:0] wd, input logic [7:0] be);
        int f = find(pf, vf, va);
        int r = reg_no(addr);
        if (f < 0 || r < 0) begin
            if (err_m != 16'hFFFF) err_m++;
        end else if (r >= 3) begin
            for (int b = 0; b < 8; b++) if (be[b]) scr_m[f][r-3][8*b +: 8] = wd[8*b +: 8];
        end
        drive(1'b1, pf, vf, va, addr, wd, be);
        @(negedge clk);
        chk("wr_ready_n2", 64'(bus.req_ready), 64'd1);
        chk("wr_no_rsp", 64'(bus.rsp_valid), 64'd0);
        chk("err_cnt_wr", 64'(bus.err_cnt), 64'(err_m));
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_pf = '0;
        bus.req_vf = '0; bus.req_va = 1'b0; bus.req_wdata = '0; bus.req_be = '0;
        bus.req_tag = '0; bus.rsp_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.rsp_data, 64'h0);
        chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
        rst = 1'b0;
        chk("ready_low_at_release", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        chk("ready_after_release", 64'(bus.req_ready), 64'd1);

        rd(3'd0, 11'd1, 1'b1, 20'h20018, 0, d);
        chk("plan_first_read", d, 64'h0);
        wr(3'd0, 11'd1, 1'b1, 20'h20018, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        rd(3'd0, 11'd1, 1'b1, 20'h20018, 0, d);
        chk("plan_full_write", d, 64'hDEADBEEF_CAFEF00D);
        rd(3'd0, 11'd0, 1'b1, 20'h20018, 0, d);
        chk("plan_func0_isolated", d, 64'h0);
        wr(3'd0, 11'd1, 1'b1, 20'h20018, 64'h1111_2222_3333_4444, 8'h0F);
        rd(3'd0, 11'd1, 1'b1, 20'h20018, 0, d);
        chk("plan_be_write", d, 64'hDEADBEEF_33334444);
        wr(3'd0, 11'd1, 1'b1, 20'h20018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        rd(3'd0, 11'd1, 1'b1, 20'h20018, 0, d);
        chk("plan_be_zero", d, 64'hDEADBEEF_33334444);

        rd(3'd5, 11'd0, 1'b0, 20'h20008, 0, d);
        chk("plan_unmapped_data", d, 64'h0);
        chk("plan_err_cnt_1", 64'(bus.err_cnt), 64'd1);
        wr(3'd0, 11'd0, 1'b1, 20'h20008, 64'h0123_4567_89AB_CDEF, 8'hFF);
        rd(3'd0, 11'd0, 1'b1, 20'h20008, 0, d);
        chk("plan_guid_ro", d, 64'h8A1A_5C3B_0F11_0001);
        chk("plan_err_cnt_still_1", 64'(bus.err_cnt), 64'd1);
        rd(3'd3, 11'd77, 1'b0, 20'h20000, 0, d);
        chk("plan_va0_ignores_vf", d, 64'h1000_0000_0000_0004);

        rd(3'd0, 11'd1, 1'b1, 20'h20018, 5, d);

        for (int it = 0; it < 60; it++) begin
            int pick = $urandom_range(0, 5);
            int kind = $urandom_range(0, 9);
            logic [2:0] pf = 3'($urandom);
            logic [10:0] vf = 11'($urandom_range(0, 3));
            logic va = 1'($urandom);
            logic [19:0] addr = BASE + 20'(8 * $urandom_range(0, 6));
            if (pick < NF) begin
                pf = DEFAULT_TABLE[pick].pf;
                va = DEFAULT_TABLE[pick].va;
                vf = va ? DEFAULT_TABLE[pick].vf : 11'($urandom);
            end
            if (kind == 0) addr = addr + 20'($urandom_range(1, 7));
            if (kind == 1) addr = BASE - 20'(8 * $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) wr(pf, vf, va, addr, {$urandom, $urandom}, 8'($urandom));
            else rd(pf, vf, va, addr, $urandom_range(0, 2), d);
        end

        rd_start(3'd0, 11'd1, 1'b1, 20'h20018);
        chk("pre_rst_scratch_nonzero", 64'(bus.rsp_data != 64'h0), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_in_resp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_in_resp_ready", 64'(bus.req_ready), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(3'd0, 11'd1, 1'b1, 20'h20018, 0, d);
        chk("post_rst_scratch", d, 64'h0);
        rd(3'd0, 11'd2, 1'b1, 20'h20020, 0, d);
        chk("post_rst_scratch1", d, 64'h0);

        force dut.err_q = 16'hFFFF;
        @(negedge clk);
        release dut.err_q;
        err_m = 16'hFFFF;
        rd(3'd7, 11'd0, 1'b1, 20'h20000, 0, d);
        chk("err_cnt_saturated", 64'(bus.err_cnt), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/csr_func_responder.md
Name: csr_func_responder

Overview:
- Parametrised MMIO CSR responder serving NUM_FUNCS PCIe functions, each identified by a (PF, VF, VA) tuple.
- Each function exposes a feature register window at FEAT_BASE:
  - DFH at +0x0, GUID_L at +0x8, GUID_H at +0x10 (read-only);
  - NUM_SCRATCH 64-bit scratchpads from +0x18, 8-byte stride.
- Sits behind the host-channel MMIO demux and replaces per-test hardcoded PF/VF/VA routing constants with one table-driven block.
- Adds per-function scratch state, byte-enable writes, error reporting and response backpressure.

Parameters:
- NUM_FUNCS, 4, number of routed functions (1..16).
- NUM_SCRATCH, 2, scratchpads per function (1..8).
- ADDR_W, 20, MMIO byte-address width.
- FEAT_BASE, 20'h20000, base offset of the feature window.
- FUNC_TABLE, csr_func_pkg::DEFAULT_TABLE, array [NUM_FUNCS] of func_entry_t {pf, vf, va, dfh, guid_l, guid_h}.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  MMIO request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address, 8-byte aligned.
- req_pf  in  3  physical function.
- req_vf  in  11  virtual function.
- req_va  in  1  VF active.
- req_wdata  in  64  write data.
- req_be  in  8  byte enables (writes only).
- req_tag  in  10  read tag.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  read response accepted.
- rsp_data  out  64  read data.
- rsp_tag  out  10  echoed tag.
- rsp_err  out  1  unmapped function/address.
- err_cnt  out  16  saturating count of unmapped accesses.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, err_cnt=0.
  - All scratchpads 0, FSM IDLE.
  - req_ready rises the first cycle after reset deasserts.
- FSM IDLE -> LOOKUP -> (RESP | IDLE):
  - IDLE: req_ready=1. On acceptance, register the request and go to LOOKUP. req_ready=0 in every other state; one transaction is outstanding at a time.
  - LOOKUP: compare (pf, vf, va) against all FUNC_TABLE entries in parallel.
    - VF compare only when va=1; when va=0, vf is ignored.
    - Lowest matching index wins.
    - Decode offset = req_addr - FEAT_BASE. Valid offsets: 0x0..0x18+8*(NUM_SCRATCH-1); offsets below FEAT_BASE are unmapped.
    - Write: apply in this cycle, then go to IDLE. No response is issued.
    - Read: load rsp_* and go to RESP.
  - RESP: rsp_valid=1. Hold rsp_data, rsp_tag, rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- Latency:
  - Read accepted at cycle N -> rsp_valid at N+2.
  - Write accepted at N -> scratch updated at the N+2 edge; req_ready high again at N+2.
  - Back-to-back reads: next acceptance no earlier than one cycle after the response handshake.
- Writes:
  - Byte lane i is updated only where req_be[i]=1.
  - Writes to DFH/GUID offsets are silently dropped and are not errors.
  - req_be=0 is a no-op.
- Unmapped access (no table match or offset out of range):
  - Reads return rsp_data=0, rsp_err=1.
  - Writes are dropped.
  - Both increment err_cnt, which saturates at 16'hFFFF.
- Misaligned address (req_addr[2:0]!=0): treated as unmapped.
- Reset mid-transaction: in-flight request discarded, pending response lost, scratchpads cleared.

Decomposition:
- Package csr_func_pkg:
  - func_entry_t struct.
  - Register offset localparams DFH_OFF=0x0, GUID_L_OFF=0x8, GUID_H_OFF=0x10, SCRATCH_OFF=0x18.
  - DEFAULT_TABLE (HE-LB PF0 VF0 VA1, HE-MEM PF0 VF1 VA1, HE-HSSI PF0 VF2 VA1, VirtIO PF3 VA0).
  - Function-ID widths and MAX_FUNCS.
- Sub-module csr_func_match: combinational parallel tuple compare plus priority encoder -> {hit, idx}.

Test Plan:
- Reset, then read func1 scratch0 (PF0 VF1 VA1, addr 0x20018) -> rsp_data=0, rsp_err=0, rsp_valid at N+2, tag echoed.
- Write 64'hDEADBEEF_CAFEF00D, be=8'hFF to func1 scratch0, then read -> 64'hDEADBEEF_CAFEF00D. Func0 scratch0 still reads 0.
- Write 64'h1111_2222_3333_4444, be=8'h0F over that value -> read returns 64'hDEADBEEF_33334444.
- Read PF5 (unmapped) at 0x20008 -> rsp_data=0, rsp_err=1, err_cnt=1. Write to GUID_L of func0 -> GUID unchanged, err_cnt unchanged.
- Read with rsp_ready held low 5 cycles -> rsp_valid, rsp_data, rsp_tag stable throughout and req_ready=0. Handshake completes on the 6th cycle.
- Assert rst while in RESP -> rsp_valid=0 immediately, scratchpads read 0 afterward. Also force err_cnt to 16'hFFFF, issue one unmapped read -> err_cnt stays 16'hFFFF.
